nand_unit_arbiter: RTL



---
 rtl/nand_unit_if.sv | 28 ++
 rtl/nand_unit_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/nand_unit_if.sv
// Request/result bundle between the gate-test clients and nand_unit_arbiter.
// The master side drives requests, operands and acks. The slave side is the arbiter.
interface nand_unit_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in1;
  logic [NREQ*WIDTH-1:0] in2;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      y;
  logic                  y_valid;
  logic [IDW-1:0]        y_id;
  logic                  resp_ack;
  logic                  busy;

  modport master (
    output req, in1, in2, resp_ack,
    input  gnt, y, y_valid, y_id, busy
  );

  modport slave (
    input  req, in1, in2, resp_ack,
    output gnt, y, y_valid, y_id, busy
  );
endinterface

// File: rtl/nand_unit_arbiter.sv
// Arbitrates NREQ clients onto one registered NAND unit and holds the tagged result until acked.
// Define ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins fixed priority.
module nand_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  nand_unit_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [IDW-1:0]   y_id_q, y_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             busy_q;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [IDW-1:0]   ptr_next;

  // NOTE: combinational blocks use blocking '=' with a default for every signal first,
  // so later statements see earlier results and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      idx = IDW'(k);
`else
      idx = IDW'((int'(ptr_q) + k) % NREQ);
`endif
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    a_sel = WIDTH'(bus.in1 >> (int'(win_idx) * WIDTH));
    b_sel = WIDTH'(bus.in2 >> (int'(win_idx) * WIDTH));
  end

  // The pointer moves past the owner of the result just acknowledged.
  assign ptr_next = (y_id_q == IDW'(NREQ - 1)) ? '0 : y_id_q + IDW'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = EVAL;
      EVAL:    state_d = RESP;
      RESP:    if (bus.resp_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = '0;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_id_d    = y_id_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d  = NREQ'(1) << win_idx;
          y_id_d = win_idx;
          a_d    = a_sel;
          b_d    = b_sel;
        end
      end
      EVAL: begin
        y_d       = ~(a_q & b_q);
        y_valid_d = 1'b1;
      end
      RESP: begin
        if (bus.resp_ack) begin
          y_valid_d = 1'b0;
          ptr_d     = ptr_next;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<='; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_id_q    <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_id_q    <= y_id_d;
      ptr_q     <= ptr_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // NOTE: the operand latches are left unreset; they are always loaded before EVAL reads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.gnt     = gnt_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_id    = y_id_q;
  assign bus.busy    = busy_q;
endmodule
